// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package mem_arbiter_pkg;

  // Transaction FSM: grant in IDLE, present request in REQ, await data in WAIT.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Owner identifiers for the single outstanding transaction.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Write length encodings (byte count).
  localparam logic [3:0] WLEN_1 = 4'd1;
  localparam logic [3:0] WLEN_2 = 4'd2;
  localparam logic [3:0] WLEN_4 = 4'd4;
  localparam logic [3:0] WLEN_8 = 4'd8;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IFU and LSU.
// Default: fixed priority, LSU wins on a simultaneous request.
// With MEM_ARB_RR_EN defined: round-robin, the requester not granted last
// wins a tie; the last-grant pointer updates on every grant.
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  input  logic idle_i,
  output logic grant_valid_o,
  output logic grant_lsu_o
);

`ifdef MEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  // Pick a winner; on a tie the side that did not win last time goes first.
  always_comb begin
    grant_valid_o = idle_i & (ifu_valid_i | lsu_valid_i);
    grant_lsu_o   = lsu_valid_i & (~ifu_valid_i | (last_q == OWN_IFU));
    last_d        = last_q;
    if (grant_valid_o) begin
      last_d = grant_lsu_o ? OWN_LSU : OWN_IFU;
    end
  end

  // Last-grant pointer, resets to IFU so the LSU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_IFU;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: any LSU request beats the IFU.
  always_comb begin
    grant_valid_o = idle_i & (ifu_valid_i | lsu_valid_i);
    grant_lsu_o   = lsu_valid_i;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU fetch, LSU load/store) arbiter onto one memory port with
// exactly one transaction outstanding. Optional round-robin arbitration is
// enabled by defining MEM_ARB_RR_EN (see mem_arb_grant).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [63:0]       ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [63:0]       lsu_wdata,
  input  logic [3:0]        lsu_wlen,
  output logic              lsu_rsp_valid,
  output logic [63:0]       lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [63:0]       mem_wdata,
  output logic [3:0]        mem_wlen,
  output logic              mem_ren,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rdata
);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [3:0]          wlen_q, wlen_d;
  logic [63:0]         ifu_rdata_q, ifu_rdata_d;
  logic [63:0]         lsu_rdata_q, lsu_rdata_d;
  logic                ifu_rsp_q, ifu_rsp_d;
  logic                lsu_rsp_q, lsu_rsp_d;
  logic                grant_valid;
  logic                grant_lsu;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk           (clk),
    .rst_n         (rst_n),
`endif
    .ifu_valid_i   (ifu_req_valid),
    .lsu_valid_i   (lsu_req_valid),
    .idle_i        (state_q == ST_IDLE),
    .grant_valid_o (grant_valid),
    .grant_lsu_o   (grant_lsu)
  );

  // Next-state, capture and handshake outputs; stray responses outside WAIT fall through.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wlen_d        = wlen_q;
    ifu_rdata_d   = ifu_rdata_q;
    lsu_rdata_d   = lsu_rdata_q;
    ifu_rsp_d     = 1'b0;
    lsu_rsp_d     = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_REQ;
          if (grant_lsu) begin
            lsu_req_ready = 1'b1;
            owner_d       = OWN_LSU;
            addr_d        = lsu_addr;
            wen_d         = lsu_wen;
            wdata_d       = lsu_wdata;
            wlen_d        = lsu_wlen;
          end else begin
            // Fetches are always full-width reads.
            ifu_req_ready = 1'b1;
            owner_d       = OWN_IFU;
            addr_d        = ifu_addr;
            wen_d         = 1'b0;
            wdata_d       = '0;
            wlen_d        = WLEN_8;
          end
        end
      end
      ST_REQ: begin
        // A response arriving alongside the handshake is not the answer yet.
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rdata_d = mem_rdata;
            lsu_rsp_d   = 1'b1;
          end else begin
            ifu_rdata_d = mem_rdata;
            ifu_rsp_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IFU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wlen_q      <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ifu_rsp_q   <= 1'b0;
      lsu_rsp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wlen_q      <= wlen_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      ifu_rsp_q   <= ifu_rsp_d;
      lsu_rsp_q   <= lsu_rsp_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wlen      = wlen_q;
  assign mem_ren       = mem_req_valid & ~wen_q;
  assign ifu_rsp_valid = ifu_rsp_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rsp_valid = lsu_rsp_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of transactions with a
// response scoreboard, plus reset-abandon and back-to-back arbitration runs.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [63:0] ifu_addr = '0;
  logic        ifu_rsp_valid;
  logic [63:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [63:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [63:0] lsu_wdata = '0;
  logic [3:0]  lsu_wlen = '0;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_wlen;
  logic        mem_ren;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wlen(lsu_wlen),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wlen(mem_wlen), .mem_ren(mem_ren),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [63:0] ifu_a;
    logic [63:0] lsu_a;
    logic        wen;
    logic [63:0] wdata;
    logic [3:0]  wlen;
    logic [63:0] rdata;
    int          stall;
    int          lat;
    logic        stray;
    logic        exp_lsu_fp;
    logic        exp_lsu_rr;
  } vec_t;

  typedef struct {
    logic        lsu;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [3:0]  wlen;
    logic [63:0] rdata;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic lv, input logic [63:0] ia,
                              input logic [63:0] la, input logic w, input logic [63:0] wd,
                              input logic [3:0] wl, input logic [63:0] rd, input int st,
                              input int lt, input logic sr, input logic efp, input logic err);
    vec_t v;
    v.ifu_v = iv; v.lsu_v = lv; v.ifu_a = ia; v.lsu_a = la; v.wen = w; v.wdata = wd;
    v.wlen = wl; v.rdata = rd; v.stall = st; v.lat = lt; v.stray = sr;
    v.exp_lsu_fp = efp; v.exp_lsu_rr = err;
    return v;
  endfunction

  task automatic run_txn(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    e.lsu   = RR ? v.exp_lsu_rr : v.exp_lsu_fp;
    e.addr  = e.lsu ? v.lsu_a : v.ifu_a;
    e.wen   = e.lsu ? v.wen : 1'b0;
    e.wdata = e.lsu ? v.wdata : 64'h0;
    e.wlen  = e.lsu ? v.wlen : 4'd8;
    e.rdata = v.rdata;
    sb.push_back(e);
    // Grant cycle
    @(negedge clk);
    ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
    lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a;
    lsu_wen = v.wen; lsu_wdata = v.wdata; lsu_wlen = v.wlen;
    #1;
    check("grant_lsu_ready", {63'h0, lsu_req_ready}, {63'h0, e.lsu});
    check("grant_ifu_ready", {63'h0, ifu_req_ready}, {63'h0, ~e.lsu});
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    // REQ cycles, optionally stalled with stray responses
    for (int s = 0; s <= v.stall; s++) begin
      check("req_valid", {63'h0, mem_req_valid}, 64'h1);
      check("req_addr", mem_addr, e.addr);
      check("req_wdata", mem_wdata, e.wdata);
      check("req_wen", {63'h0, mem_wen}, {63'h0, e.wen});
      check("req_ren", {63'h0, mem_ren}, {63'h0, ~e.wen});
      check("req_wlen", {60'h0, mem_wlen}, {60'h0, e.wlen});
      check("req_readies", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
      check("req_no_rsp", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
      mem_req_ready = (s == v.stall);
      mem_rsp_valid = v.stray && (s == v.stall || s == 1);
      mem_rdata     = ~e.rdata;
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    // WAIT cycles before the real response
    for (int w = 0; w < v.lat; w++) begin
      check("wait_no_req", {63'h0, mem_req_valid}, 64'h0);
      check("wait_no_rsp", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
      @(negedge clk);
    end
    check("wait_no_rsp", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
    mem_rsp_valid = 1'b1; mem_rdata = e.rdata;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
    got = sb.pop_front();
    check("rsp_lsu_valid", {63'h0, lsu_rsp_valid}, {63'h0, got.lsu});
    check("rsp_ifu_valid", {63'h0, ifu_rsp_valid}, {63'h0, ~got.lsu});
    check("rsp_rdata", got.lsu ? lsu_rdata : ifu_rdata, got.rdata);
    $display("txn %0d owner=%s addr=0x%0h wen=%0d wlen=%0d rdata=0x%0h", idx,
             got.lsu ? "LSU" : "IFU", got.addr, got.wen, got.wlen, got.rdata);
    @(negedge clk);
    check("rsp_one_pulse", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
  endtask

  initial begin
    int   grants;
    logic pend;
    logic exp_lsu;

    //        ifu  lsu  ifu_addr        lsu_addr  wen   wdata          wlen  rdata       st lt stray fp    rr
    vecs[0] = mk(1'b1, 1'b0, 64'h8000_0000, 64'h0,   1'b0, 64'h0,         4'd0, 64'h1234,   0, 1, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 1'b1, 64'h0,         64'h100, 1'b1, 64'hAB,        4'd1, 64'h0,      0, 0, 1'b0, 1'b1, 1'b1);
    vecs[2] = mk(1'b1, 1'b1, 64'h200,       64'h300, 1'b0, 64'h0,         4'd8, 64'h5555,   0, 1, 1'b0, 1'b1, 1'b0);
    vecs[3] = mk(1'b1, 1'b1, 64'h400,       64'h500, 1'b1, 64'hDEAD,      4'd4, 64'h0,      1, 0, 1'b0, 1'b1, 1'b1);
    vecs[4] = mk(1'b0, 1'b1, 64'h0,         64'h600, 1'b0, 64'h0,         4'd8, 64'hCAFE,   5, 2, 1'b1, 1'b1, 1'b1);
    vecs[5] = mk(1'b1, 1'b0, 64'h700,       64'h0,   1'b0, 64'h0,         4'd0, 64'hBEEF,   2, 3, 1'b1, 1'b0, 1'b0);
    vecs[6] = mk(1'b1, 1'b1, 64'h800,       64'h900, 1'b0, 64'h0,         4'd2, 64'h77,     0, 0, 1'b0, 1'b1, 1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
    check("rst_outputs", {58'h0, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_wen, mem_ren}, 64'h0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_wlen", {60'h0, mem_wlen}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    // Idle with a stray response: nothing happens
    mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("idle_stray_rsp", {61'h0, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 64'h0);
    check("idle_stray_rdata", ifu_rdata | lsu_rdata, 64'h0);

    foreach (vecs[i]) run_txn(i, vecs[i]);

    // Reset during WAIT abandons the load and ignores the late response
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 64'h1000; lsu_wen = 1'b0; lsu_wlen = 4'd8;
    #1 check("rstw_grant", {63'h0, lsu_req_ready}, 64'h1);
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstw_req_valid", {63'h0, mem_req_valid}, 64'h0);
    check("rstw_addr", mem_addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h99;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rstw_no_rsp", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
      check("rstw_outputs", {60'h0, mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready}, 64'h0);
      check("rstw_rdata", lsu_rdata, 64'h0);
      @(negedge clk);
    end
    $display("txn reset-in-WAIT done");

    // Both requesters held valid, memory answers promptly
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 64'hA000; lsu_addr = 64'hB000; lsu_wen = 1'b0;
    mem_req_ready = 1'b1;
    pend = 1'b0;
    grants = 0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      #1;
      if (ifu_rsp_valid || lsu_rsp_valid)
        check("b2b_grant_on_rsp", {63'h0, ifu_req_ready | lsu_req_ready}, 64'h1);
      if (ifu_req_ready || lsu_req_ready) begin
        exp_lsu = RR ? ((grants % 2) == 0) : 1'b1;
        check("alt_grant", {63'h0, lsu_req_ready}, {63'h0, exp_lsu});
        $display("txn b2b grant %0d owner=%s", grants, lsu_req_ready ? "LSU" : "IFU");
        grants++;
      end
      mem_rsp_valid = 1'b0;
      if (pend) begin
        mem_rsp_valid = 1'b1; mem_rdata = 64'h42 + 64'(c); pend = 1'b0;
      end else if (mem_req_valid) begin
        pend = 1'b1;
      end
      @(negedge clk);
    end
    check("b2b_grant_count", 64'(grants), 64'd4);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
